// File: rtl/interrupt_ack_controller_pkg.sv
// Shared types and helpers for the interrupt acknowledge controller.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } irq_ack_state_t;

  // A single line still needs a one-bit vector.
  function automatic int vec_width(input int num_irq);
    return (num_irq <= 1) ? 1 : $clog2(num_irq);
  endfunction

endpackage

// File: rtl/interrupt_ack_controller_if.sv
// CPU/pending-logic signal bundle for the interrupt acknowledge controller.
interface interrupt_ack_controller_if
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 3
);
  localparam int VEC_W = vec_width(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               cpu_ack;
  logic               cpu_eoi;
  logic               err_clr;
  logic               cpu_irq;
  logic [VEC_W-1:0]   irq_vector;
  logic [NUM_IRQ-1:0] irq_clear;
  logic               in_service;
  logic               timeout_err;

  modport master (
    output irq_pending, irq_mask, cpu_ack, cpu_eoi, err_clr,
    input  cpu_irq, irq_vector, irq_clear, in_service, timeout_err
  );

  modport slave (
    input  irq_pending, irq_mask, cpu_ack, cpu_eoi, err_clr,
    output cpu_irq, irq_vector, irq_clear, in_service, timeout_err
  );
endinterface

// File: rtl/interrupt_ack_controller_encoder.sv
// Combinational priority encoder: lowest set index wins.
module irq_priority_encoder #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);
  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end
endmodule

// File: rtl/interrupt_ack_controller.sv
// Interrupt presentation/acknowledge FSM with ack timeout and clear pulse.
module interrupt_ack_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ     = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  interrupt_ack_controller_if.slave bus
);
  localparam int VEC_W = vec_width(NUM_IRQ);

  irq_ack_state_t     state;
  logic [7:0]         wait_cnt;
  logic [NUM_IRQ-1:0] eligible;
  logic               win_valid;
  logic [VEC_W-1:0]   win_idx;
  logic               latched_ok;

  assign eligible   = bus.irq_pending & ~bus.irq_mask;
  assign latched_ok = eligible[bus.irq_vector];

  irq_priority_encoder #(
    .N (NUM_IRQ),
    .W (VEC_W)
  ) u_enc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      wait_cnt        <= '0;
      bus.cpu_irq     <= 1'b0;
      bus.irq_vector  <= '0;
      bus.irq_clear   <= '0;
      bus.in_service  <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.irq_clear <= '0;
      // A timeout set later in this block overrides the clear.
      if (bus.err_clr) bus.timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            bus.irq_vector <= win_idx;
            bus.cpu_irq    <= 1'b1;
            wait_cnt       <= '0;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.cpu_ack) begin
            bus.irq_clear  <= NUM_IRQ'(1) << bus.irq_vector;
            bus.cpu_irq    <= 1'b0;
            bus.in_service <= 1'b1;
            state          <= ST_SERVICE;
          end else if (wait_cnt == 8'(ACK_TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            bus.cpu_irq     <= 1'b0;
            state           <= ST_IDLE;
          end else if (!latched_ok) begin
            bus.cpu_irq <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_SERVICE: begin
          if (bus.cpu_eoi) begin
            bus.in_service <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: begin
          bus.cpu_irq    <= 1'b0;
          bus.in_service <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_interrupt_ack_controller.sv
// Directed self-checking bench for interrupt_ack_controller.
module tb_interrupt_ack_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  interrupt_ack_controller_if #(.NUM_IRQ(3)) bus ();

  interrupt_ack_controller #(
    .NUM_IRQ     (3),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.irq_pending = 3'b000;
    bus.irq_mask    = 3'b000;
    bus.cpu_ack     = 1'b0;
    bus.cpu_eoi     = 1'b0;
    bus.err_clr     = 1'b0;

    // Reset state
    step(); step();
    check("rst_cpu_irq", 32'(bus.cpu_irq), 0);
    check("rst_vector", 32'(bus.irq_vector), 0);
    check("rst_clear", 32'(bus.irq_clear), 0);
    check("rst_in_service", 32'(bus.in_service), 0);
    check("rst_timeout", 32'(bus.timeout_err), 0);
    rst_n = 1'b1;
    $display("reset released");

    // Basic present / ack / eoi
    bus.irq_pending = 3'b110;
    step();
    check("t1_cpu_irq", 32'(bus.cpu_irq), 1);
    check("t1_vector", 32'(bus.irq_vector), 1);
    check("t1_clear_req", 32'(bus.irq_clear), 0);
    bus.cpu_ack = 1'b1;
    step();
    check("t1_clear_pulse", 32'(bus.irq_clear), 3'b010);
    check("t1_in_service", 32'(bus.in_service), 1);
    check("t1_cpu_irq_svc", 32'(bus.cpu_irq), 0);
    bus.cpu_ack = 1'b0;
    bus.irq_pending = 3'b100;
    step();
    check("t1_clear_off", 32'(bus.irq_clear), 0);
    check("t1_in_service2", 32'(bus.in_service), 1);
    check("t1_vector_hold", 32'(bus.irq_vector), 1);
    bus.cpu_eoi = 1'b1;
    bus.irq_pending = 3'b000;
    step();
    check("t1_eoi_in_service", 32'(bus.in_service), 0);
    check("t1_eoi_cpu_irq", 32'(bus.cpu_irq), 0);
    bus.cpu_eoi = 1'b0;
    $display("txn basic ack/eoi done");

    // Masked line skipped, then withdraw by mask
    bus.irq_pending = 3'b101;
    bus.irq_mask = 3'b001;
    step();
    check("t2_cpu_irq", 32'(bus.cpu_irq), 1);
    check("t2_vector", 32'(bus.irq_vector), 2);
    bus.irq_mask = 3'b111;
    step();
    check("t2_withdraw_irq", 32'(bus.cpu_irq), 0);
    check("t2_withdraw_clear", 32'(bus.irq_clear), 0);
    check("t2_withdraw_svc", 32'(bus.in_service), 0);
    bus.irq_mask = 3'b000;
    bus.irq_pending = 3'b000;
    step();
    $display("txn mask/withdraw done");

    // Ack timeout after 16 REQ cycles; set coincides with err_clr
    bus.irq_pending = 3'b001;
    step();
    check("t3_req_irq", 32'(bus.cpu_irq), 1);
    for (int i = 0; i < 15; i++) begin
      step();
      check("t3_wait_irq", 32'(bus.cpu_irq), 1);
      check("t3_wait_clear", 32'(bus.irq_clear), 0);
    end
    check("t3_no_err_yet", 32'(bus.timeout_err), 0);
    bus.irq_pending = 3'b000;
    bus.err_clr = 1'b1;
    step();
    check("t3_timeout_err", 32'(bus.timeout_err), 1);
    check("t3_timeout_irq", 32'(bus.cpu_irq), 0);
    check("t3_timeout_clear", 32'(bus.irq_clear), 0);
    bus.err_clr = 1'b0;
    step();
    check("t3_err_sticky", 32'(bus.timeout_err), 1);
    bus.err_clr = 1'b1;
    step();
    check("t3_err_clr", 32'(bus.timeout_err), 0);
    bus.err_clr = 1'b0;
    $display("txn timeout done");

    // Pending drop withdraws; drop with ack still clears
    bus.irq_pending = 3'b010;
    step();
    check("t4_req_irq", 32'(bus.cpu_irq), 1);
    bus.irq_pending = 3'b000;
    step();
    check("t4_drop_irq", 32'(bus.cpu_irq), 0);
    check("t4_drop_clear", 32'(bus.irq_clear), 0);
    bus.irq_pending = 3'b010;
    step();
    check("t4_req2_irq", 32'(bus.cpu_irq), 1);
    bus.irq_pending = 3'b000;
    bus.cpu_ack = 1'b1;
    step();
    check("t4_ackwins_clear", 32'(bus.irq_clear), 3'b010);
    check("t4_ackwins_svc", 32'(bus.in_service), 1);
    bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b1;
    step();
    check("t4_eoi_svc", 32'(bus.in_service), 0);
    bus.cpu_eoi = 1'b0;
    $display("txn drop/ack race done");

    // Ack and eoi together in REQ: eoi ignored
    bus.irq_pending = 3'b100;
    step();
    check("t5_vector", 32'(bus.irq_vector), 2);
    bus.irq_pending = 3'b000;
    bus.cpu_ack = 1'b1;
    bus.cpu_eoi = 1'b1;
    step();
    check("t5_clear", 32'(bus.irq_clear), 3'b100);
    check("t5_svc", 32'(bus.in_service), 1);
    bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b0;
    step();
    check("t5_svc_held", 32'(bus.in_service), 1);
    check("t5_clear_off", 32'(bus.irq_clear), 0);
    bus.cpu_eoi = 1'b1;
    step();
    check("t5_eoi_svc", 32'(bus.in_service), 0);
    bus.cpu_eoi = 1'b0;
    $display("txn ack+eoi done");

    // Async reset during SERVICE
    bus.irq_pending = 3'b001;
    step();
    bus.cpu_ack = 1'b1;
    bus.irq_pending = 3'b000;
    step();
    check("t6_svc", 32'(bus.in_service), 1);
    bus.cpu_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_svc", 32'(bus.in_service), 0);
    check("t6_async_clear", 32'(bus.irq_clear), 0);
    check("t6_async_vector", 32'(bus.irq_vector), 0);
    check("t6_async_irq", 32'(bus.cpu_irq), 0);
    bus.irq_pending = 3'b010;
    step();
    rst_n = 1'b1;
    step();
    check("t6_first_arb_irq", 32'(bus.cpu_irq), 1);
    check("t6_first_arb_vec", 32'(bus.irq_vector), 1);
    bus.irq_pending = 3'b000;
    step();
    check("t6_withdraw_irq", 32'(bus.cpu_irq), 0);
    bus.cpu_ack = 1'b1;
    bus.cpu_eoi = 1'b1;
    step();
    check("t6_idle_ack_svc", 32'(bus.in_service), 0);
    check("t6_idle_ack_clear", 32'(bus.irq_clear), 0);
    check("t6_idle_ack_irq", 32'(bus.cpu_irq), 0);
    bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b0;
    $display("txn reset/idle ack done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/interrupt_ack_controller.md
INTERRUPT_ACK_CONTROLLER -- requirements
Module: interrupt_ack_controller

Interface
REQ-001 Parameter NUM_IRQ, default 3, SHALL set the number of interrupt lines.
REQ-002 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum number of REQ cycles allowed for cpu_ack; legal range 2..255.
REQ-003 Localparam VEC_W SHALL be max(1, clog2(NUM_IRQ)).
REQ-004 clk  input  1  single clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 irq_pending  input  NUM_IRQ  pending vector from the pending-capture logic.
REQ-007 irq_mask  input  NUM_IRQ  1 masks the line.
REQ-008 cpu_ack  input  1  CPU accepts the presented interrupt.
REQ-009 cpu_eoi  input  1  CPU signals end of service.
REQ-010 err_clr  input  1  clears timeout_err.
REQ-011 cpu_irq  output  1  interrupt request to the CPU.
REQ-012 irq_vector  output  VEC_W  index of the presented or in-service line.
REQ-013 irq_clear  output  NUM_IRQ  one-hot, one-cycle clear pulse back to the pending logic.
REQ-014 in_service  output  1  an acknowledged interrupt is being serviced.
REQ-015 timeout_err  output  1  sticky flag indicating an acknowledge timeout.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, REQ, SERVICE.
REQ-017 Eligible lines SHALL be irq_pending & ~irq_mask; the lowest eligible index has the highest priority.
REQ-018 In IDLE with at least one eligible line, the block SHALL latch the winning index into irq_vector and enter REQ on the next edge.
REQ-019 cpu_irq SHALL be a registered output equal to (state==REQ), so it asserts 1 cycle after eligibility is seen in IDLE.
REQ-020 irq_vector SHALL remain stable for the whole of REQ and SERVICE; no re-arbitration occurs outside IDLE.
REQ-021 In REQ with cpu_ack=1, the block SHALL enter SERVICE and drive irq_clear[irq_vector]=1 for exactly the next cycle; all other irq_clear bits stay 0.
REQ-022 In REQ, if the latched line is no longer eligible (pending dropped or mask set) and cpu_ack=0, the block SHALL return to IDLE without a clear pulse.
REQ-023 In REQ, if cpu_ack=1 and the latched line is no longer eligible in the same cycle, the ack SHALL win.
REQ-024 An 8-bit wait counter SHALL reset to 0 on REQ entry and increment each REQ cycle.
REQ-025 When the wait counter equals ACK_TIMEOUT-1 with cpu_ack=0, the block SHALL set timeout_err, return to IDLE, and issue no clear pulse.
REQ-026 In SERVICE, in_service=1 and cpu_irq=0; cpu_eoi=1 SHALL return the FSM to IDLE, with in_service=0 on the next cycle.
REQ-027 cpu_ack outside REQ and cpu_eoi outside SERVICE SHALL be ignored.
REQ-028 If cpu_ack and cpu_eoi are both 1 in REQ, the eoi SHALL be ignored.
REQ-029 In IDLE, eligibility is re-evaluated every cycle, so back-to-back interrupts need at least 1 IDLE cycle after SERVICE.
REQ-030 timeout_err SHALL stay set until err_clr=1; when a set and err_clr coincide, the set SHALL win.

Reset
REQ-031 While rst_n=0, the block SHALL hold state=IDLE, cpu_irq=0, irq_vector=0, irq_clear=0, in_service=0, timeout_err=0, and wait counter=0.
REQ-032 Reset asserted in REQ or SERVICE SHALL abort immediately with no clear pulse issued.
REQ-033 After rst_n deasserts, the first arbitration SHALL occur on the first clock edge.

Structure
REQ-034 Package irq_pkg SHALL hold the FSM state enum (irq_ack_state_t) and the VEC_W computation function.
REQ-035 Sub-module irq_priority_encoder (combinational, lowest-index-wins, with a valid output) SHALL be used for arbitration.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 pending=3'b110, mask=0 -> vector=1 and cpu_irq=1 one cycle later; ack -> irq_clear=3'b010 for exactly 1 cycle, in_service=1; eoi -> IDLE.
REQ-038 pending=3'b101, mask=3'b001 -> vector=2 is presented.
REQ-039 No ack for 16 REQ cycles -> timeout_err=1, cpu_irq=0, irq_clear never asserted; err_clr -> timeout_err=0.
REQ-040 Latched line's pending drops in REQ -> withdraw to IDLE without clear; the same drop coincident with ack -> clear pulse issued.
REQ-041 rst_n pulsed low during SERVICE -> all outputs 0 asynchronously; eoi and ack while IDLE -> no effect.
REQ-042 Simultaneous ack and eoi in REQ -> SERVICE entered, in_service=1 held until a later eoi.
